label_map_reader: RTL and testbench

//  Reader side of the label SRAM. After the labeler has filled the 32x32 label map
//  (1024 x 8-bit, row-major, addr = row*32+col), this block scans it, repacks it

---
 rtl/label_map_reader_pkg.sv | 40 ++++
 rtl/label_map_reader_byte_packer.sv | 44 ++++
 rtl/label_map_reader.sv | 130 +++++++++++++
 tb/tb_label_map_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/label_map_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : label_map_reader_pkg
//  Desc     : Shared constants, state encoding and the pixel bit-order helper
//             used by the label map reader and its byte packer.
//  Revision : 1.0  initial release
// ============================================================================
package label_map_reader_pkg;

  localparam int IMG_PIX      = 1024;              // pixels in the label map
  localparam int DW           = 8;                 // label / output byte width
  localparam int SAW          = 10;                // SRAM address width
  localparam int OAW          = 7;                 // output byte address width
  localparam int PIX_PER_BYTE = 8;
  localparam int CW           = $clog2(IMG_PIX) + 1; // count 0..IMG_PIX without wrap

  localparam logic [OAW-1:0] LAST_BYTE = OAW'(IMG_PIX / PIX_PER_BYTE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A pixel is "on" in the bitmap when its label is nonzero.
  function automatic logic is_labeled(input logic [DW-1:0] q);
    return (q != '0);
  endfunction

  // Bit order shared with the labeler: the leftmost pixel of a group of eight
  // ends up in bit 7. Shifting left and inserting at the LSB achieves this
  // after eight captures.
  function automatic logic [DW-1:0] pack_shift(input logic [DW-1:0] acc,
                                               input logic          px);
    return {acc[DW-2:0], px};
  endfunction

endpackage
`default_nettype wire

// File: rtl/label_map_reader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : label_byte_packer
//  Desc     : Packs eight captured labels into one bitmap byte (MSB first) and
//             keeps the running nonzero-pixel count and maximum label.
//  Revision : 1.0  initial release
// ============================================================================
module label_byte_packer
  import label_map_reader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          capture,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] byte_next,
  output logic [CW-1:0] pix_count,
  output logic [DW-1:0] max_label
);

  logic [DW-1:0] shift_q;

  // Byte as it will look once the current q is shifted in.
  assign byte_next = pack_shift(shift_q, is_labeled(q));

  // Shift register plus running statistics, cleared on reset or a new scan.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q   <= '0;
      pix_count <= '0;
      max_label <= '0;
    end else if (capture) begin
      shift_q <= byte_next;
      if (is_labeled(q)) begin
        pix_count <= pix_count + CW'(1);
      end
      if (q > max_label) begin
        max_label <= q;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/label_map_reader.sv
`default_nettype none
// ============================================================================
//  Module   : label_map_reader
//  Desc     : Scans the 32x32 label SRAM, streams it out as a 128-byte binary
//             bitmap with a valid/ready handshake, and reports the labeled
//             pixel count and the highest label seen.
//  Revision : 1.0  initial release
// ============================================================================
module label_map_reader
  import label_map_reader_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [DW-1:0]  sram_q,
  output logic [SAW-1:0] sram_a,
  output logic [DW-1:0]  out_data,
  output logic [OAW-1:0] out_addr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  pix_count,
  output logic [DW-1:0]  max_label,
  output logic           finish
);

  // READ phase: cycles 0..7 present addresses, cycles 1..8 capture data.
  localparam logic [3:0] RD_LAST_ADDR = 4'd7;
  localparam logic [3:0] RD_LAST_CAP  = 4'd8;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     rd_cnt;
  logic [OAW-1:0] byte_idx;   // index of the byte currently being assembled
  logic           scan_start;
  logic           capture;
  logic [DW-1:0]  byte_next;

  assign scan_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign capture    = (state == ST_READ) && (rd_cnt != 4'd0);

  label_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (scan_start),
    .capture   (capture),
    .q         (sram_q),
    .byte_next (byte_next),
    .pix_count (pix_count),
    .max_label (max_label)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only acts when idle/done; EMIT waits for ready.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = ST_READ;
      end
      ST_READ: begin
        if (rd_cnt == RD_LAST_CAP) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) state_nxt = (out_addr == LAST_BYTE) ? ST_DONE : ST_READ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address sequencing, output byte register and handshake bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt    <= '0;
      byte_idx  <= '0;
      sram_a    <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rd_cnt   <= '0;
            byte_idx <= '0;
            sram_a   <= '0;
            finish   <= 1'b0;
          end
        end
        ST_READ: begin
          // Address advances only through the eight pixels of this byte,
          // then holds its last value until the next byte starts.
          if (rd_cnt < RD_LAST_ADDR) begin
            sram_a <= sram_a + SAW'(1);
          end
          if (rd_cnt == RD_LAST_CAP) begin
            rd_cnt    <= '0;
            out_data  <= byte_next;
            out_addr  <= byte_idx;
            out_valid <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt + 4'd1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_addr == LAST_BYTE) begin
              finish <= 1'b1;
            end else begin
              byte_idx <= byte_idx + OAW'(1);
              sram_a   <= {byte_idx + OAW'(1), 3'b000};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_label_map_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_label_map_reader
//  Desc     : Randomized scoreboard bench for label_map_reader with an SRAM
//             model and a bitmap reference computed directly from the map.
//  Revision : 1.0  initial release
// ============================================================================
module tb_label_map_reader;

  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic [7:0]  out_data;
  logic [6:0]  out_addr;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] pix_count;
  logic [7:0]  max_label;
  logic        finish;

  logic [7:0]  mem [0:1023];
  logic [14:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  label_map_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sram_q    (sram_q),
    .sram_a    (sram_a),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_count (pix_count),
    .max_label (max_label),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data for an address appears one cycle later.
  always @(posedge clk) sram_q <= mem[sram_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte the DUT hands over is compared with the queue head.
  always @(negedge clk) begin
    logic [14:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {25'd0, out_addr}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_addr", {25'd0, out_addr}, {25'd0, e[14:8]});
        check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
      end
    end
  end

  // Reference: bitmap byte k bit (7-j) is set when pixel 8k+j is nonzero.
  task automatic load_expect(output int pc, output int ml);
    logic [7:0] b;
    logic [6:0] ka;
    pc = 0;
    ml = 0;
    for (int k = 0; k < 128; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (mem[8*k+j] != 8'h00) begin
          b[7-j] = 1'b1;
          pc++;
        end
        if (int'(mem[8*k+j]) > ml) ml = int'(mem[8*k+j]);
      end
      ka = k[6:0];
      exp_q.push_back({ka, b});
    end
  endtask

  // mode: 0 ready=1, 1 random ready, 2 stall at byte 3, 3 start pulses mid-scan
  task automatic run_scan(input int mode, input int abort_at);
    int pc, ml, cyc;
    logic [7:0] hd;
    logic [6:0] ha;
    logic [9:0] hs;
    bit stalled, pulsed;
    exp_q.delete();
    load_expect(pc, ml);
    stalled = 0;
    pulsed  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clr_finish",    {31'd0, finish}, 32'd0);
    check("clr_pix_count", {21'd0, pix_count}, 32'd0);
    check("clr_max_label", {24'd0, max_label}, 32'd0);
    cyc = 0;
    while (!finish && cyc < LIMIT) begin
      start = 1'b0;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 3 && cyc == 5) start = 1'b1;
      if (mode == 3 && out_valid && out_addr == 7'd10 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (abort_at >= 0 && out_valid && int'(out_addr) == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_sram_a",    {22'd0, sram_a}, 32'd0);
        check("rst_out_data",  {24'd0, out_data}, 32'd0);
        check("rst_out_addr",  {25'd0, out_addr}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pix_count", {21'd0, pix_count}, 32'd0);
        check("rst_max_label", {24'd0, max_label}, 32'd0);
        check("rst_finish",    {31'd0, finish}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (mode == 2 && out_valid && out_addr == 7'd3 && !stalled) begin
        stalled   = 1;
        out_ready = 1'b0;
        hd = out_data;
        ha = out_addr;
        hs = sram_a;
        repeat (20) begin
          @(posedge clk); #1;
          cyc++;
          check("stall_data",   {24'd0, out_data}, {24'd0, hd});
          check("stall_addr",   {25'd0, out_addr}, {25'd0, ha});
          check("stall_sram_a", {22'd0, sram_a}, {22'd0, hs});
          check("stall_valid",  {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!finish) begin
      check("finish_timeout", 32'd0, 32'd1);
      return;
    end
    if (mode == 0 || mode == 3) check("finish_latency", cyc, 32'd1280);
    check("bytes_outstanding", exp_q.size(), 32'd0);
    check("pix_count", {21'd0, pix_count}, pc);
    check("max_label", {24'd0, max_label}, ml);
    check("final_sram_a", {22'd0, sram_a}, 32'd1023);
    check("final_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("finish_held", {31'd0, finish}, 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sram_a",    {22'd0, sram_a}, 32'd0);
    check("reset_out_data",  {24'd0, out_data}, 32'd0);
    check("reset_out_addr",  {25'd0, out_addr}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_pix_count", {21'd0, pix_count}, 32'd0);
    check("reset_max_label", {24'd0, max_label}, 32'd0);
    check("reset_finish",    {31'd0, finish}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // All-zero map.
    run_scan(0, -1);

    // Single label in the last pixel.
    mem[1023] = 8'h05;
    run_scan(0, -1);

    // Checkerboard, nonzero at (0,0).
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        mem[r*32+c] = (((r + c) % 2) == 0) ? 8'h01 : 8'h00;
    run_scan(0, -1);

    // Same map with a 20-cycle stall on byte 3.
    run_scan(2, -1);

    // Reset in the middle of the scan, then a full rescan.
    fill_random();
    run_scan(0, 40);
    @(posedge clk); #1;
    run_scan(1, -1);

    // Start pulses during READ and EMIT, then a restart from DONE.
    fill_random();
    run_scan(3, -1);
    fill_random();
    run_scan(0, -1);

    // A few more random maps under random back-pressure.
    repeat (3) begin
      fill_random();
      run_scan(1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
